// File: rtl/io_bus_master_if.sv
// IOB master bundle: bridge request/status signals plus the 68000-style IOB pins.
interface io_bus_master_if;
  logic IORDREQ;
  logic IOWRREQ;
  logic IOL0;
  logic IOU0;
  logic nDTACK_IOB;
  logic nBERR_IOB;
  logic nVPA_IOB;
  logic E_IOB;
  logic nAS_IOB;
  logic nLDS_IOB;
  logic nUDS_IOB;
  logic nRW_IOB;
  logic nVMA_IOB;
  logic nDoutOE;
  logic RDLE;
  logic IOACT;
  logic IODONE;
  logic IOBERR;

  modport master (
    input  IORDREQ, IOWRREQ, IOL0, IOU0,
    input  nDTACK_IOB, nBERR_IOB, nVPA_IOB, E_IOB,
    output nAS_IOB, nLDS_IOB, nUDS_IOB, nRW_IOB, nVMA_IOB, nDoutOE,
    output RDLE, IOACT, IODONE, IOBERR
  );

  modport slave (
    output IORDREQ, IOWRREQ, IOL0, IOU0,
    output nDTACK_IOB, nBERR_IOB, nVPA_IOB, E_IOB,
    input  nAS_IOB, nLDS_IOB, nUDS_IOB, nRW_IOB, nVMA_IOB, nDoutOE,
    input  RDLE, IOACT, IODONE, IOBERR
  );
endinterface

// File: rtl/io_bus_master.sv
// IOB bus master: runs 68000-style DTACK/BERR/VPA-E bus cycles for the I/O bridge.
// Define IOBM_TIMEOUT_EN to force a bus error after TIMEOUT_CYCLES cycles without termination.
module io_bus_master #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             CLK,
  input logic             RST,
  io_bus_master_if.master bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badParams
    $error("io_bus_master: parameter out of legal range");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_S1, ST_S2, ST_WAIT, ST_EWLO, ST_EWHI, ST_EWEND, ST_DATA, ST_END, ST_RECOVER
  } state_t;

  // Bus responses are inverted to active-high before synchronizing.
  logic [7:0] w_raw;
  logic [7:0] r_sync [SYNC_STAGES];
  logic       w_rdReqS, w_wrReqS, w_lS, w_uS, w_dtackS, w_berrS, w_vpaS, w_eS, w_reqS;

  assign w_raw = {bus.IORDREQ, bus.IOWRREQ, bus.IOL0, bus.IOU0,
                  !bus.nDTACK_IOB, !bus.nBERR_IOB, !bus.nVPA_IOB, bus.E_IOB};

  always_ff @(posedge CLK) begin
    r_sync[0] <= w_raw;
    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
  end

  assign {w_rdReqS, w_wrReqS, w_lS, w_uS, w_dtackS, w_berrS, w_vpaS, w_eS} = r_sync[SYNC_STAGES-1];
  assign w_reqS = w_rdReqS | w_wrReqS;

  state_t r_state;
  logic   r_reqSeen, r_write, r_l, r_u;
  logic   r_nAs, r_nLds, r_nUds, r_nRw, r_nVma, r_nDoutOe;
  logic   r_rdle, r_ioAct, r_ioDone, r_ioBerr;
  logic   w_timeout;

`ifdef IOBM_TIMEOUT_EN
  logic [7:0] r_tmoCnt;
  assign w_timeout = (r_tmoCnt == 8'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_reqSeen <= 1'b0;
      r_write   <= 1'b0;
      r_l       <= 1'b0;
      r_u       <= 1'b0;
      r_nAs     <= 1'b1;
      r_nLds    <= 1'b1;
      r_nUds    <= 1'b1;
      r_nRw     <= 1'b1;
      r_nVma    <= 1'b1;
      r_nDoutOe <= 1'b1;
      r_rdle    <= 1'b0;
      r_ioAct   <= 1'b0;
      r_ioDone  <= 1'b0;
      r_ioBerr  <= 1'b0;
`ifdef IOBM_TIMEOUT_EN
      r_tmoCnt  <= 8'd0;
`endif
    end else begin
      // A request must be seen low before another can be accepted.
      if (!w_reqS) r_reqSeen <= 1'b0;
`ifdef IOBM_TIMEOUT_EN
      if (r_state inside {ST_WAIT, ST_EWLO, ST_EWHI, ST_EWEND}) r_tmoCnt <= r_tmoCnt + 8'd1;
`endif
      r_rdle <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_reqS && !r_reqSeen) begin
            r_reqSeen <= 1'b1;
            r_ioAct   <= 1'b1;
            r_ioDone  <= 1'b0;
            r_ioBerr  <= 1'b0;
            r_l       <= w_lS;
            r_u       <= w_uS;
            r_write   <= w_wrReqS && !w_rdReqS;
            r_nRw     <= !(w_wrReqS && !w_rdReqS);
            r_nDoutOe <= !(w_wrReqS && !w_rdReqS);
            r_state   <= ST_S1;
          end
        end
        ST_S1: begin
          r_nAs <= 1'b0;
          if (!r_write) begin
            r_nLds <= !r_l;
            r_nUds <= !r_u;
          end
          r_state <= ST_S2;
        end
        ST_S2: begin
          if (r_write) begin
            r_nLds <= !r_l;
            r_nUds <= !r_u;
          end
`ifdef IOBM_TIMEOUT_EN
          r_tmoCnt <= 8'd0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_berrS || w_timeout) begin
            r_ioBerr <= 1'b1;
            r_state  <= ST_END;
          end else if (w_dtackS) begin
            r_state <= ST_DATA;
          end else if (w_vpaS) begin
            r_state <= ST_EWLO;
          end
        end
        ST_EWLO: begin
          if (w_berrS || w_timeout) begin
            r_ioBerr <= 1'b1;
            r_state  <= ST_END;
          end else if (!w_eS) begin
            r_nVma  <= 1'b0;
            r_state <= ST_EWHI;
          end
        end
        ST_EWHI: begin
          if (w_berrS || w_timeout) begin
            r_ioBerr <= 1'b1;
            r_state  <= ST_END;
          end else if (w_eS) begin
            r_state <= ST_EWEND;
          end
        end
        ST_EWEND: begin
          if (w_berrS || w_timeout) begin
            r_ioBerr <= 1'b1;
            r_state  <= ST_END;
          end else if (!w_eS) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_rdle  <= !r_write;
          r_state <= ST_END;
        end
        ST_END: begin
          r_nAs    <= 1'b1;
          r_nLds   <= 1'b1;
          r_nUds   <= 1'b1;
          r_nVma   <= 1'b1;
          r_ioDone <= 1'b1;
          r_state  <= ST_RECOVER;
        end
        ST_RECOVER: begin
          r_nDoutOe <= 1'b1;
          r_nRw     <= 1'b1;
          if (!w_dtackS && !w_berrS && !w_vpaS) begin
            r_ioAct <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.nAS_IOB  = r_nAs;
  assign bus.nLDS_IOB = r_nLds;
  assign bus.nUDS_IOB = r_nUds;
  assign bus.nRW_IOB  = r_nRw;
  assign bus.nVMA_IOB = r_nVma;
  assign bus.nDoutOE  = r_nDoutOe;
  assign bus.RDLE     = r_rdle;
  assign bus.IOACT    = r_ioAct;
  assign bus.IODONE   = r_ioDone;
  assign bus.IOBERR   = r_ioBerr;

endmodule
